data_memory_bytelane: RTL

Parametrised successor to the processor's single-port data memory. Byte-addressed storage with lb/lh/lw/lbu/lhu/sb/sh/sw access sizes, alignment and range checking, and a configurable set of FSM states in which access is allowed. A sequential clear engine replaces bulk reset, and a registered debug read port replaces the per-word visualisation outputs. Sits between the ALU result/register file and the write-back mux of the multicycle core.

---
 rtl/data_memory_bytelane.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_bytelane.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane
//
// Byte-addressed data memory for the multicycle core. Holds DEPTH 32-bit words
// and serves lb/lh/lw/lbu/lhu loads and sb/sh/sw stores from the ALU result
// address. Accesses are only honoured in the control-FSM states enabled by
// ACC_MASK. A sequential clear engine zeroes the array after reset or on
// request, and a registered debug port exposes any word for inspection.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   estado        current control-FSM state (indexes ACC_MASK)
//   aluresult2    byte address from the ALU
//   readdata2R    store data (low byte / half used for sb / sh)
//   memwrite      store request
//   memread       load request
//   funct3        access size and signedness (000 lb, 001 lh, 010 lw,
//                 100 lbu, 101 lhu; stores use funct3[1:0] as the size)
//   clr           start-clear pulse (honoured only when idle)
//   dbg_addr      debug word index
//   reddataM      extended load result
//   rd_valid      one-cycle pulse when reddataM is updated
//   writedataR    registered aluresult2 of the last accepted access
//   err_misalign  one-cycle pulse on a misaligned access
//   err_range     one-cycle pulse on an out-of-range access
//   busy          clear engine active
//   dbg_data      word at dbg_addr, one cycle of latency
// -----------------------------------------------------------------------------
module data_memory_bytelane #(
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 32,
    parameter logic [15:0] ACC_MASK = 16'h00C8,
    parameter int          IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        estado,
    input  logic [ADDR_W-1:0] aluresult2,
    input  logic [31:0]       readdata2R,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [2:0]        funct3,
    input  logic              clr,
    input  logic [IDX_W-1:0]  dbg_addr,
    output logic [31:0]       reddataM,
    output logic              rd_valid,
    output logic [31:0]       writedataR,
    output logic              err_misalign,
    output logic              err_range,
    output logic              busy,
    output logic [31:0]       dbg_data
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Encoded access size as carried in funct3[1:0].
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] clr_idx_q;
    logic [IDX_W-1:0] clr_idx_d;

    assign busy = (state_q == ST_CLEAR);

    // -------------------------------------------------------------------------
    // Address decode and access qualification
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    size_t            size;
    logic             range_err;
    logic             misalign;
    logic             accept;
    logic             access_ok;

    assign word_idx = aluresult2[IDX_W+1:2];
    assign offset   = aluresult2[1:0];
    assign size     = size_t'(funct3[1:0]);

    // Any address bit above the word index points past the end of the array.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range
            assign range_err = |aluresult2[ADDR_W-1:IDX_W+2];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

    // NOTE: every combinational output gets a default before the case/if
    // tree so that no path leaves it unassigned and infers a latch.
    always_comb begin
        misalign = 1'b0;
        case (size)
            SZ_HALF: misalign = offset[0];
            SZ_WORD: misalign = (offset != 2'b00);
            SZ_BAD:  misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
        // There is no unsigned word (110) or unsigned double (111) access.
        if (funct3[2] && funct3[1]) begin
            misalign = 1'b1;
        end
    end

    // A clear request in the same cycle wins over the access, which is lost.
    assign accept    = ACC_MASK[estado] && (memwrite || memread)
                       && (state_q == ST_IDLE) && !clr;
    assign access_ok = accept && !misalign && !range_err;

    // -------------------------------------------------------------------------
    // Load path: lane select and extension from the currently stored word
    // -------------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_signed;
    logic [31:0] load_data;

    assign rd_word   = mem[word_idx];
    assign ld_byte   = rd_word[{offset, 3'b000} +: 8];
    assign ld_half   = offset[1] ? rd_word[31:16] : rd_word[15:0];
    assign ld_signed = !funct3[2];

    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: load_data = rd_word;
        endcase
    end

    // -------------------------------------------------------------------------
    // Store path: byte-lane enables and lane-replicated data
    // -------------------------------------------------------------------------
    logic [3:0]  st_be;
    logic [31:0] st_data;

    always_comb begin
        st_be   = 4'b0000;
        st_data = readdata2R;
        case (size)
            SZ_BYTE: begin
                st_be   = 4'b0001 << offset;
                st_data = {4{readdata2R[7:0]}};
            end
            SZ_HALF: begin
                st_be   = offset[1] ? 4'b1100 : 4'b0011;
                st_data = {2{readdata2R[15:0]}};
            end
            SZ_WORD: begin
                st_be   = 4'b1111;
                st_data = readdata2R;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = readdata2R;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Single write port shared by the clear engine and stores. While busy no
    // access can be accepted, so the two sources never collide.
    // -------------------------------------------------------------------------
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_be   = 4'b0000;
        wr_data = 32'h0000_0000;
        if (busy) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0000_0000;
        end else if (access_ok && memwrite) begin
            wr_en   = 1'b1;
            wr_idx  = word_idx;
            wr_be   = st_be;
            wr_data = st_data;
        end
    end

    // NOTE: the array has no reset term; it is zeroed by the clear engine
    // instead, which keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Clear-engine FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                // clr is ignored here; the sweep always runs to the last word.
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered state and outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what gives a combined
    // memread+memwrite its read-before-write behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= '0;
            reddataM     <= 32'h0000_0000;
            rd_valid     <= 1'b0;
            writedataR   <= 32'h0000_0000;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            dbg_data     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            rd_valid     <= access_ok && memread;
            err_misalign <= accept && misalign;
            err_range    <= accept && range_err;
            dbg_data     <= mem[dbg_addr];
            if (accept) begin
                writedataR <= 32'(aluresult2);
            end
            if (access_ok && memread) begin
                reddataM <= load_data;
            end
        end
    end

endmodule
